// File: rtl/pam_polyphase_shaper.sv
// 4-PAM polyphase pulse-shaping interpolator: each 2-bit symbol is expanded into OSR samples
// through run-time loadable, double-buffered tap banks, a shift-add product stage and a registered adder tree.
module pam_polyphase_shaper #(
    parameter int WIDTH  = 18,
    parameter int COEF_W = 18,
    parameter int NSYM   = 23,
    parameter int OSR    = 4,
    parameter int AW     = 7
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     sam_clk_en,
    input  logic                     sym_clk_en,
    input  logic [1:0]               sym_in,
    input  logic                     coef_wr_en,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     coef_swap,
    output logic                     coef_busy,
    output logic signed [WIDTH-1:0]  y,
    output logic                     y_valid,
    output logic                     sat,
    output logic                     sync_err
);

    localparam int NTAP   = NSYM * OSR;
    localparam int LVL    = $clog2(NSYM);
    localparam int PW     = $clog2(OSR);
    localparam int PROD_W = COEF_W + 2;
    localparam int ACC_W  = PROD_W + LVL;
    localparam int HALF   = (NSYM + 1) / 2;

    localparam logic [PW-1:0]            PH_LAST = PW'(OSR - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX   = ACC_W'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN   = ACC_W'(-(2 ** (WIDTH - 1)));

    // Number of live nodes on tree level lvl (level 0 holds the NSYM products).
    function automatic int node_cnt(input int lvl);
        return (NSYM + (1 << lvl) - 1) >> lvl;
    endfunction

    logic [PW-1:0]            phase_reg;
    logic [1:0]               sym_reg [NSYM];
    logic [NSYM-1:0]          tap_vld_reg;
    logic                     seen_reg;
    logic                     sync_err_reg;
    logic                     pend_reg;
    logic                     smp_vld_reg;
    logic signed [COEF_W-1:0] coef_shd_reg [NTAP];
    logic signed [COEF_W-1:0] coef_act_reg [NTAP];

    logic sym_take;
    logic commit;
    logic addr_ok;

    assign sym_take  = sam_clk_en & sym_clk_en;
    assign commit    = pend_reg & sym_take;
    assign addr_ok   = (int'(coef_addr) < NTAP);
    assign coef_busy = pend_reg;
    assign sync_err  = sync_err_reg;

    // Symbol delay line, phase counter and alignment monitor.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            phase_reg    <= '0;
            tap_vld_reg  <= '0;
            seen_reg     <= 1'b0;
            sync_err_reg <= 1'b0;
            smp_vld_reg  <= 1'b0;
            for (int k = 0; k < NSYM; k++) begin
                sym_reg[k] <= '0;
            end
        end else begin
            smp_vld_reg <= sam_clk_en;
            if (sym_clk_en && (!sam_clk_en || (seen_reg && phase_reg != PH_LAST))) begin
                sync_err_reg <= 1'b1;
            end
            if (sam_clk_en) begin
                if (sym_clk_en) begin
                    sym_reg[0]  <= sym_in;
                    for (int k = 1; k < NSYM; k++) begin
                        sym_reg[k] <= sym_reg[k-1];
                    end
                    tap_vld_reg <= {tap_vld_reg[NSYM-2:0], 1'b1};
                    phase_reg   <= '0;
                    seen_reg    <= 1'b1;
                end else begin
                    phase_reg <= (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
                end
            end
        end
    end

    // The commit reads the shadow before this edge's write lands, so a same-edge write is not committed.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            pend_reg <= 1'b0;
            for (int i = 0; i < NTAP; i++) begin
                coef_shd_reg[i] <= '0;
                coef_act_reg[i] <= '0;
            end
        end else begin
            if (commit) begin
                coef_act_reg <= coef_shd_reg;
                pend_reg     <= 1'b0;
            end else if (coef_swap) begin
                pend_reg <= 1'b1;
            end
            if (coef_wr_en && addr_ok) begin
                coef_shd_reg[coef_addr] <= coef_data;
            end
        end
    end

    logic signed [PROD_W-1:0] prod_next [NSYM];

    for (genvar gi = 0; gi < NSYM; gi++) begin : g_tap
        logic signed [COEF_W-1:0] coef_sel;
        logic signed [PROD_W-1:0] h_ext;
        logic signed [PROD_W-1:0] h_x3;

        always_comb begin
            coef_sel = '0;
            for (int p = 0; p < OSR; p++) begin
                if (phase_reg == PW'(p)) begin
                    coef_sel = coef_act_reg[gi*OSR + p];
                end
            end
        end

        assign h_ext = PROD_W'(coef_sel);
        assign h_x3  = (h_ext <<< 1) + h_ext;

        assign prod_next[gi] = !tap_vld_reg[gi]       ? '0     :
                               (sym_reg[gi] == 2'b00) ? -h_x3  :
                               (sym_reg[gi] == 2'b01) ? -h_ext :
                               (sym_reg[gi] == 2'b10) ? h_ext  : h_x3;
    end

    // Row width NSYM+1 keeps every pair index in range; nodes past a level's count stay zero.
    logic signed [ACC_W-1:0] tree_reg [LVL+1][NSYM+1];
    logic [LVL:0]            tree_vld_reg;
    logic signed [ACC_W-1:0] rnd_reg;
    logic                    rnd_vld_reg;
    logic signed [WIDTH-1:0] y_reg;
    logic                    y_valid_reg;
    logic                    sat_reg;

    always_ff @(posedge sys_clk) begin
        for (int k = 0; k < NSYM; k++) begin
            tree_reg[0][k] <= ACC_W'(prod_next[k]);
        end
        tree_reg[0][NSYM] <= '0;
        for (int l = 1; l <= LVL; l++) begin
            for (int j = 0; j < HALF; j++) begin
                if (j >= node_cnt(l)) begin
                    tree_reg[l][j] <= '0;
                end else if (2*j + 1 < node_cnt(l - 1)) begin
                    tree_reg[l][j] <= tree_reg[l-1][2*j] + tree_reg[l-1][2*j+1];
                end else begin
                    tree_reg[l][j] <= tree_reg[l-1][2*j];
                end
            end
            for (int j = HALF; j <= NSYM; j++) begin
                tree_reg[l][j] <= '0;
            end
        end
        rnd_reg <= (tree_reg[LVL][0] + ACC_W'(2)) >>> 2;
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tree_vld_reg <= '0;
            rnd_vld_reg  <= 1'b0;
            y_reg        <= '0;
            y_valid_reg  <= 1'b0;
            sat_reg      <= 1'b0;
        end else begin
            tree_vld_reg <= {tree_vld_reg[LVL-1:0], smp_vld_reg};
            rnd_vld_reg  <= tree_vld_reg[LVL];
            y_valid_reg  <= rnd_vld_reg;
            if (rnd_vld_reg) begin
                if (rnd_reg > Y_MAX) begin
                    y_reg   <= Y_MAX[WIDTH-1:0];
                    sat_reg <= 1'b1;
                end else if (rnd_reg < Y_MIN) begin
                    y_reg   <= Y_MIN[WIDTH-1:0];
                    sat_reg <= 1'b1;
                end else begin
                    y_reg   <= rnd_reg[WIDTH-1:0];
                    sat_reg <= 1'b0;
                end
            end
        end
    end

    assign y       = y_reg;
    assign y_valid = y_valid_reg;
    assign sat     = sat_reg;

endmodule

// File: tb/tb_pam_polyphase_shaper.sv
// Randomised bench for pam_polyphase_shaper: a queue-based symbol history and integer tap banks
// predict every output sample, which is compared cycle by cycle against the DUT.
module tb_pam_polyphase_shaper;

    localparam int WIDTH     = 18;
    localparam int COEF_W    = 18;
    localparam int NSYM      = 23;
    localparam int OSR       = 4;
    localparam int AW        = 7;
    localparam int NTAP      = NSYM * OSR;
    localparam int LAT       = 8;
    localparam int EXP_DEPTH = 8192;
    localparam longint Y_HI  = 131071;
    localparam longint Y_LO  = -131072;

    logic              sys_clk = 1'b0;
    logic              reset;
    logic              sam_clk_en;
    logic              sym_clk_en;
    logic [1:0]        sym_in;
    logic              coef_wr_en;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              coef_swap;
    logic              coef_busy;
    logic [WIDTH-1:0]  y;
    logic              y_valid;
    logic              sat;
    logic              sync_err;

    pam_polyphase_shaper #(
        .WIDTH (WIDTH),
        .COEF_W(COEF_W),
        .NSYM  (NSYM),
        .OSR   (OSR),
        .AW    (AW)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .sam_clk_en(sam_clk_en),
        .sym_clk_en(sym_clk_en),
        .sym_in    (sym_in),
        .coef_wr_en(coef_wr_en),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_swap (coef_swap),
        .coef_busy (coef_busy),
        .y         (y),
        .y_valid   (y_valid),
        .sat       (sat),
        .sync_err  (sync_err)
    );

    always #5 sys_clk = ~sys_clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     edge_no = 0;
    int     shd_m [NTAP];
    int     act_m [NTAP];
    int     hist_m [$];
    int     ph_m;
    bit     seen_m, err_m, pend_m;
    bit     exp_vld [EXP_DEPTH];
    longint exp_y   [EXP_DEPTH];
    bit     exp_sat [EXP_DEPTH];
    longint hold_y;
    bit     hold_sat;
    bit     capture = 1'b0;
    longint cap_q [$];

    task automatic check_val(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, want, edge_no);
        end
    endtask

    function automatic int sym_level(input int s);
        case (s)
            0:       return -3;
            1:       return -1;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    // Predicts the effect of the upcoming clock edge from the stimulus about to be applied.
    task automatic model_edge(input bit sam, input bit sym, input int s, input bit wr,
                              input int addr, input int data, input bit swap);
        int     e;
        longint acc, q, v;
        bit     st;
        e = edge_no + 1 + LAT;
        if (e >= EXP_DEPTH) begin
            $display("FAIL bench_depth: got %0d expected below %0d", e, EXP_DEPTH);
            $fatal(1);
        end
        if (sym && (!sam || (seen_m && ph_m != OSR - 1))) err_m = 1'b1;
        if (pend_m && sam && sym) begin
            act_m  = shd_m;
            pend_m = 1'b0;
        end else if (swap) begin
            pend_m = 1'b1;
        end
        if (wr && addr < NTAP) shd_m[addr] = data;
        if (sam) begin
            if (sym) begin
                hist_m.push_front(sym_level(s));
                if (hist_m.size() > NSYM) void'(hist_m.pop_back());
                ph_m   = 0;
                seen_m = 1'b1;
            end else begin
                ph_m = (ph_m + 1) % OSR;
            end
            acc = 0;
            foreach (hist_m[k]) acc += longint'(hist_m[k]) * longint'(act_m[k*OSR + ph_m]);
            q = acc + 2;
            v = (q >= 0) ? q / 4 : -((-q + 3) / 4);
            st = 1'b0;
            if (v > Y_HI) begin v = Y_HI; st = 1'b1; end
            if (v < Y_LO) begin v = Y_LO; st = 1'b1; end
            exp_vld[e] = 1'b1;
            exp_y[e]   = v;
            exp_sat[e] = st;
        end
    endtask

    task automatic check_outputs();
        if (exp_vld[edge_no]) begin
            hold_y   = exp_y[edge_no];
            hold_sat = exp_sat[edge_no];
        end
        check_val("y_valid", longint'(y_valid), longint'(exp_vld[edge_no]));
        check_val("y", longint'($signed(y)), hold_y);
        check_val("sat", longint'(sat), longint'(hold_sat));
        check_val("sync_err", longint'(sync_err), longint'(err_m));
        check_val("coef_busy", longint'(coef_busy), longint'(pend_m));
        if (y_valid) begin
            $display("edge %0d: sample y=%0d sat=%0d", edge_no, $signed(y), sat);
            if (capture) cap_q.push_back(longint'($signed(y)));
        end
    endtask

    task automatic drive_edge(input bit sam, input bit sym, input int s, input bit wr,
                              input int addr, input int data, input bit swap);
        sam_clk_en = sam;
        sym_clk_en = sym;
        sym_in     = 2'(s);
        coef_wr_en = wr;
        coef_addr  = AW'(addr);
        coef_data  = COEF_W'(data);
        coef_swap  = swap;
        model_edge(sam, sym, s, wr, addr, data, swap);
        @(posedge sys_clk);
        edge_no++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_edge(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    function automatic int rand_coef(input int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    // kind 0: random in +/-lim, 1: every tap = lim, 2: only tap 5 = lim.
    task automatic load_bank(input int kind, input int lim);
        int val;
        for (int i = 0; i < NTAP; i++) begin
            case (kind)
                0:       val = rand_coef(lim);
                1:       val = lim;
                default: val = (i == 5) ? lim : 0;
            endcase
            drive_edge(1'b0, 1'b0, 0, 1'b1, i, val, 1'b0);
        end
    endtask

    task automatic swap_edge();
        drive_edge(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic rand_edge(input bit sam, input bit sym, input int s, input int wr_pct,
                             input int swap_pct, input int lim);
        bit wr, sw;
        wr = int'($urandom_range(99)) < wr_pct;
        sw = int'($urandom_range(99)) < swap_pct;
        drive_edge(sam, sym, s, wr, int'($urandom_range(127)), rand_coef(lim), sw);
    endtask

    // pat 0: random symbols, 1: all 11, 2: all 00, 3: 11 then 00.
    task automatic run_symbols(input int nsym, input int pat, input int gap_pct,
                               input int wr_pct, input int swap_pct, input int lim);
        int s;
        int gaps;
        for (int si = 0; si < nsym; si++) begin
            case (pat)
                0:       s = int'($urandom_range(3));
                1:       s = 3;
                2:       s = 0;
                default: s = (si == 0) ? 3 : 0;
            endcase
            for (int p = 0; p < OSR; p++) begin
                gaps = 0;
                while (gaps < 4 && int'($urandom_range(99)) < gap_pct) begin
                    rand_edge(1'b0, 1'b0, s, wr_pct, swap_pct, lim);
                    gaps++;
                end
                rand_edge(1'b1, p == 0, s, wr_pct, swap_pct, lim);
            end
        end
    endtask

    task automatic apply_reset();
        reset      = 1'b0;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        coef_wr_en = 1'b0;
        coef_swap  = 1'b0;
        #1;
        foreach (shd_m[i]) begin
            shd_m[i] = 0;
            act_m[i] = 0;
        end
        hist_m.delete();
        ph_m = 0; seen_m = 1'b0; err_m = 1'b0; pend_m = 1'b0;
        hold_y = 0; hold_sat = 1'b0;
        for (int i = edge_no + 1; i < EXP_DEPTH; i++) exp_vld[i] = 1'b0;
        check_val("rst_y", longint'($signed(y)), 0);
        check_val("rst_y_valid", longint'(y_valid), 0);
        check_val("rst_sat", longint'(sat), 0);
        check_val("rst_sync_err", longint'(sync_err), 0);
        check_val("rst_coef_busy", longint'(coef_busy), 0);
        repeat (2) begin
            @(posedge sys_clk);
            edge_no++;
            #1;
            check_outputs();
        end
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; sam_clk_en = 1'b0; sym_clk_en = 1'b0; sym_in = '0;
        coef_wr_en = 1'b0; coef_addr = '0; coef_data = '0; coef_swap = 1'b0;
        @(posedge sys_clk);
        #1;
        apply_reset();

        // Single strobe through an empty pipe.
        drive_edge(1'b1, 1'b1, 3, 1'b0, 0, 0, 1'b0);
        idle(12);

        // Impulse response through tap 5.
        apply_reset();
        load_bank(2, 4000);
        swap_edge();
        check_val("imp_busy", longint'(coef_busy), 1);
        cap_q.delete();
        capture = 1'b1;
        run_symbols(6, 3, 0, 0, 0, 0);
        idle(LAT + 2);
        capture = 1'b0;
        check_val("imp_count", cap_q.size(), 24);
        if (cap_q.size() == 24) begin
            check_val("imp_s0p1", cap_q[1], 0);
            check_val("imp_s1p0", cap_q[4], 0);
            check_val("imp_s1p1", cap_q[5], 3000);
            check_val("imp_s2p1", cap_q[9], -3000);
        end

        // Saturation at both rails.
        apply_reset();
        load_bank(1, 131071);
        swap_edge();
        run_symbols(30, 1, 0, 0, 0, 0);
        idle(LAT + 2);
        check_val("sat_pos_y", longint'($signed(y)), Y_HI);
        check_val("sat_pos", longint'(sat), 1);
        run_symbols(30, 2, 0, 0, 0, 0);
        idle(LAT + 2);
        check_val("sat_neg_y", longint'($signed(y)), Y_LO);
        check_val("sat_neg", longint'(sat), 1);

        // Bank swap requested mid-symbol.
        apply_reset();
        load_bank(0, 20000);
        swap_edge();
        run_symbols(3, 0, 0, 0, 0, 0);
        drive_edge(1'b1, 1'b1, int'($urandom_range(3)), 1'b0, 0, 0, 1'b0);
        drive_edge(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        load_bank(0, 20000);
        drive_edge(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b1);
        check_val("busy_p2", longint'(coef_busy), 1);
        drive_edge(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        check_val("busy_p3", longint'(coef_busy), 1);
        drive_edge(1'b1, 1'b1, int'($urandom_range(3)), 1'b0, 0, 0, 1'b0);
        check_val("busy_clr", longint'(coef_busy), 0);
        run_symbols(3, 0, 0, 0, 0, 0);
        idle(LAT + 2);

        // Symbol/phase misalignment.
        apply_reset();
        run_symbols(2, 0, 0, 0, 0, 0);
        drive_edge(1'b1, 1'b1, 1, 1'b0, 0, 0, 1'b0);
        drive_edge(1'b1, 1'b0, 1, 1'b0, 0, 0, 1'b0);
        drive_edge(1'b1, 1'b0, 1, 1'b0, 0, 0, 1'b0);
        drive_edge(1'b1, 1'b1, 2, 1'b0, 0, 0, 1'b0);
        check_val("sync_early", longint'(sync_err), 1);
        drive_edge(1'b1, 1'b0, 2, 1'b0, 0, 0, 1'b0);
        drive_edge(1'b1, 1'b0, 2, 1'b0, 0, 0, 1'b0);
        drive_edge(1'b1, 1'b0, 2, 1'b0, 0, 0, 1'b0);
        run_symbols(2, 0, 0, 0, 0, 0);
        check_val("sync_sticky", longint'(sync_err), 1);
        apply_reset();
        drive_edge(1'b0, 1'b1, 0, 1'b0, 0, 0, 1'b0);
        check_val("sync_nosam", longint'(sync_err), 1);
        idle(LAT + 2);

        // Randomised streaming with gaps, concurrent writes and swaps.
        apply_reset();
        load_bank(0, 20000);
        swap_edge();
        run_symbols(40, 0, 30, 10, 5, 20000);
        load_bank(0, 131071);
        swap_edge();
        run_symbols(20, 0, 20, 5, 5, 131071);

        // Reset with samples still in flight.
        run_symbols(2, 0, 0, 0, 0, 0);
        apply_reset();
        idle(LAT + 4);
        run_symbols(2, 0, 0, 0, 0, 0);
        idle(LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
